// File: rtl/fir_mac_sequencer_if.sv
// Sample-in / result-out stream, coefficient write port and status for fir_mac_sequencer.
// The master modport is the sample source / consumer side; slave is the filter itself.
interface fir_mac_sequencer_if #(
  parameter int unsigned N      = 10,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned OUT_W  = 32
);
  localparam int unsigned AddrW = $clog2(N);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     coef_we;
  logic [AddrW-1:0]         coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     coef_err;
  logic                     busy;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data, coef_err, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, coef_err, busy
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed N-tap FIR: one shared multiplier stepped over the taps, one tap per cycle.
// Define FIR_SAT_EN to saturate the result to OUT_W; otherwise the accumulator is truncated.
module fir_mac_sequencer #(
  parameter int unsigned N      = 10,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned ACC_W  = 40
) (
  input logic                clk,
  input logic                rst,
  fir_mac_sequencer_if.slave bus
);
  localparam int unsigned AddrW = $clog2(N);
  localparam int unsigned ProdW = DATA_W + COEF_W;

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e                   state_q, state_d;
  logic [AddrW-1:0]         tap_q, tap_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] hist_q [N];
  logic signed [DATA_W-1:0] hist_d [N];
  logic signed [COEF_W-1:0] coef_q [N];
  logic signed [COEF_W-1:0] coef_d [N];
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     coef_err_q, coef_err_d;
  logic signed [ProdW-1:0]  prod;
  logic signed [OUT_W-1:0]  acc_out;
  logic                     addr_ok;

  assign prod    = hist_q[tap_q] * coef_q[tap_q];
  assign addr_ok = {1'b0, bus.coef_addr} < (AddrW + 1)'(N);

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin = ~SatMax;

  always_comb begin
    if (acc_q > SatMax) begin
      acc_out = SatMax[OUT_W-1:0];
    end else if (acc_q < SatMin) begin
      acc_out = SatMin[OUT_W-1:0];
    end else begin
      acc_out = acc_q[OUT_W-1:0];
    end
  end
`else
  assign acc_out = acc_q[OUT_W-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    hist_d      = hist_q;
    coef_d      = coef_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    coef_err_d  = 1'b0;

    // Coefficients may only change while no MAC pass can observe them half-updated.
    if (bus.coef_we) begin
      if (state_q == StIdle && addr_ok) begin
        coef_d[bus.coef_addr] = bus.coef_wdata;
      end else begin
        coef_err_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          for (int k = N - 1; k > 0; k--) begin
            hist_d[k] = hist_q[k-1];
          end
          hist_d[0] = bus.in_data;
          acc_d     = '0;
          tap_d     = '0;
          state_d   = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + ACC_W'(prod);
        tap_d = tap_q + AddrW'(1);
        if (tap_q == AddrW'(N - 1)) begin
          tap_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        // First DONE cycle registers the finished accumulator; then hold until taken.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_out;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tap_q       <= '0;
      acc_q       <= '0;
      hist_q      <= '{default: '0};
      coef_q      <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      coef_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      hist_q      <= hist_d;
      coef_q      <= coef_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      coef_err_q  <= coef_err_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.coef_err  = coef_err_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Randomised self-checking bench for fir_mac_sequencer against a dot-product reference model.
module tb_fir_mac_sequencer;
  localparam int unsigned N      = 10;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned COEF_W = 16;
  localparam int unsigned OUT_W  = 32;
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned AddrW  = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_mac_sequencer_if #(.N(N), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) bus ();

  fir_mac_sequencer #(
    .N(N), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int model_hist[N];
  int model_coef[N];

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < int'(N); k++) begin
      model_hist[k] = 0;
      model_coef[k] = 0;
    end
  endtask

  // Plain dot product of the last N samples with the coefficients, then fitted to OUT_W.
  function automatic longint model_out();
    longint sum = 0;
    for (int k = 0; k < int'(N); k++) sum += longint'(model_hist[k]) * longint'(model_coef[k]);
`ifdef FIR_SAT_EN
    if (sum > 64'sd2147483647) return 64'sd2147483647;
    if (sum < -64'sd2147483648) return -64'sd2147483648;
    return sum;
`else
    return longint'(int'(sum));
`endif
  endfunction

  function automatic int rand_s16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic write_coef(input int addr, input int data);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = AddrW'(addr);
    bus.coef_wdata = COEF_W'(data);
    tick();
    bus.coef_we = 1'b0;
    check_eq("coef_err_idle", bus.coef_err, (addr >= int'(N)));
    if (addr < int'(N)) model_coef[addr] = data;
  endtask

  // mode: 0 plain, 1 coef write during MAC, 2 coef write with the sample, 3 reset at tap 4
  task automatic send_sample(input int x, input bit tied, input int hold, input int mode);
    int     lat;
    int     wa;
    int     wd;
    longint exp;
    lat = 0;
    while (bus.in_ready !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("in_ready_wait", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.in_data   = DATA_W'(x);
    bus.out_ready = tied;
    if (mode == 2) begin
      wa             = int'($urandom_range(N - 1));
      wd             = rand_s16();
      bus.coef_we    = 1'b1;
      bus.coef_addr  = AddrW'(wa);
      bus.coef_wdata = COEF_W'(wd);
      model_coef[wa] = wd;
    end
    for (int k = int'(N) - 1; k > 0; k--) model_hist[k] = model_hist[k-1];
    model_hist[0] = x;
    exp = model_out();
    tick();
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    check_eq("busy_after_accept", bus.busy, 1);
    check_eq("in_ready_in_mac", bus.in_ready, 0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (mode == 1 && lat == 2) begin
        bus.coef_we    = 1'b1;
        bus.coef_addr  = AddrW'(3);
        bus.coef_wdata = COEF_W'(7);
      end
      if (mode == 1 && lat == 3) begin
        bus.coef_we = 1'b0;
        check_eq("coef_err_busy", bus.coef_err, 1);
      end
      if (mode == 1 && lat == 4) check_eq("coef_err_pulse_end", bus.coef_err, 0);
      if (mode == 2 && lat == 1) check_eq("coef_err_same_cycle", bus.coef_err, 0);
      if (mode == 3 && lat == 4) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_eq("abort_out_valid", bus.out_valid, 0);
        check_eq("abort_in_ready", bus.in_ready, 1);
        check_eq("abort_busy", bus.busy, 0);
        bus.out_ready = 1'b0;
        return;
      end
    end
    bus.coef_we = 1'b0;
    check_eq("latency", lat, N + 1);
    check_eq("out_data", $signed(bus.out_data), exp);
    check_eq("in_ready_in_done", bus.in_ready, 0);
    if (!tied) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        check_eq("hold_valid", bus.out_valid, 1);
        check_eq("hold_data", $signed(bus.out_data), exp);
        check_eq("hold_in_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
    end
    tick();
    bus.out_ready = 1'b0;
    check_eq("released_valid", bus.out_valid, 0);
    check_eq("released_in_ready", bus.in_ready, 1);
    check_eq("released_busy", bus.busy, 0);
  endtask

  task automatic impulse();
    send_sample(1, 1'b1, 0, 0);
    for (int i = 0; i < int'(N) - 1; i++) send_sample(0, 1'b1, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    do_reset();

    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_data", $signed(bus.out_data), 0);
    check_eq("rst_coef_err", bus.coef_err, 0);
    check_eq("rst_busy", bus.busy, 0);

    // Impulse response reads back the coefficient ramp.
    for (int k = 0; k < int'(N); k++) write_coef(k, k + 1);
    impulse();

    send_sample(rand_s16(), 1'b0, 5, 0);

    // Rejected write during MAC must leave coef[3] intact for the next impulse.
    send_sample(rand_s16(), 1'b1, 0, 1);
    impulse();
    write_coef(3, 7);
    write_coef(12, 5);
    impulse();

    send_sample(rand_s16(), 1'b1, 0, 2);
    send_sample(rand_s16(), 1'b0, 2, 2);

    do_reset();
    for (int k = 0; k < int'(N); k++) write_coef(k, -1);
    send_sample(100, 1'b1, 0, 0);
    send_sample(-50, 1'b1, 0, 0);

    for (int k = 0; k < int'(N); k++) write_coef(k, 32767);
    for (int i = 0; i < int'(N); i++) send_sample(32767, 1'b1, 0, 0);
    for (int i = 0; i < int'(N); i++) send_sample(-32768, 1'b1, 0, 0);

    send_sample(rand_s16(), 1'b1, 0, 3);
    for (int k = 0; k < int'(N); k++) write_coef(k, k + 1);
    impulse();

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(2) == 0) begin
        write_coef(int'($urandom_range(15)), rand_s16());
      end
      send_sample(rand_s16(), 1'(($urandom_range(1))), int'($urandom_range(3)),
                  int'($urandom_range(2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
